uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that sits directly downstream of the UART transmitter: it consumes the serial `TX_OUT` line as `RX_IN`, oversamples it, and recovers 8-bit frames with optional parity. Output is a parallel byte plus a one-cycle `Data_Valid` strobe, with per-frame parity and stop error flags. One oversampling clock runs the whole block. `RX_IN` is asynchronous to it and is synchronized internally.

## Interface
- `DATA_W`, 8: data bits per frame, sent LSB first.
- `PRESC_W`, 6: width of the `Prescale` input.

- `clk`  in  1  oversampling clock; `Prescale` cycles per bit.
- `rst`  in  1  asynchronous, active-high reset.
- `RX_IN`  in  1  serial line; idles high; asynchronous to `clk`.
- `Prescale`  in  PRESC_W  oversampling ratio; legal values are 8, 16 and 32 only.
- `PAR_EN`  in  1  parity bit present in the frame.
- `PAR_TYP`  in  1  parity type: 0 = even, 1 = odd.
- `P_DATA`  out  DATA_W  last good byte received.
- `Data_Valid`  out  1  one-cycle strobe: `P_DATA` was updated.
- `Par_Err`  out  1  one-cycle strobe: parity mismatch.
- `Stop_Err`  out  1  one-cycle strobe: stop bit sampled as 0.

## Operation
- Synchronizer: 2 flops on `RX_IN`, both reset to 1. The FSM sees only the synchronized signal `rx_s`.
- Counters:
  - `edge_cnt` runs 0..P-1 and wraps to 0.
  - `bit_cnt` counts bits within the frame.
- Bit sampling: `rx_s` is sampled at `edge_cnt` = P/2-1, P/2 and P/2+1. The bit value is the majority of the 3 samples, valid from `edge_cnt` = P/2+2. A bit ends at `edge_cnt` = P-1.
- Latching: `Prescale`, `PAR_EN` and `PAR_TYP` are latched on the IDLE->START transition. Changes mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `rx_s`=0, go to START with `edge_cnt`=0.
  - START: at bit end, go to DATA if the majority value is 0. Otherwise (glitch) go to IDLE with no strobes.
  - DATA: shift the majority value into a shift register, LSB first. After 8 bits, go to PARITY if `PAR_EN`=1, else go to STOP.
  - PARITY: compare the received bit with the parity of the shift register (`PAR_TYP`=0: XOR of data; `PAR_TYP`=1: inverted XOR). Record a mismatch and go to STOP.
  - STOP: at bit end, always go to IDLE and raise exactly one outcome strobe:
    - `Par_Err`=1 if a parity mismatch was recorded, regardless of the stop bit value.
    - else `Stop_Err`=1 if the stop majority is 0.
    - else `Data_Valid`=1 and `P_DATA` is loaded from the shift register.
- A frame with an error leaves `P_DATA` unchanged.
- Back-to-back frames: IDLE is re-entered at the end of the stop bit. A start bit that immediately follows is detected on the next cycle, with no lost bit.
- Reset (asynchronous, any time including mid-frame), all outputs and state:
  - FSM to IDLE.
  - `edge_cnt`, `bit_cnt` and the shift register to 0.
  - `P_DATA`=0x00, `Data_Valid`=0, `Par_Err`=0, `Stop_Err`=0.
  - Synchronizer flops to 1.
  - A partial frame is discarded.
  - After reset deasserts, the receiver resyncs on the next falling edge of `rx_s`.

## Timing
- Reference edge E0: the first `clk` edge at which the first synchronizer flop captures `RX_IN`=0.
- FSM timing from E0:
  - The FSM is in START with `edge_cnt`=0 at E0+2.
  - Bit k (start bit is k=0) occupies edges E0+2+k·P .. E0+1+(k+1)·P.
- Frame length N = 10 bits without parity, 11 with parity.
- The outcome strobe is high for exactly one cycle, starting at edge E0+1+N·P.
  - Example: P=8, no parity → E0+81.
  - Example: P=16, parity → E0+177.
- `P_DATA` changes at the same edge as `Data_Valid` and holds otherwise.
- At most one of `Data_Valid`, `Par_Err`, `Stop_Err` is high in any cycle.
- No ready or backpressure input: the consumer must accept the `Data_Valid` strobe.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately and FSM in IDLE. Then idle line for 100 cycles → no strobes.
- Clean frame: P=8, `PAR_EN`=0, byte 0xA5 → `Data_Valid` for 1 cycle at E0+81, `P_DATA`=0xA5, no error strobes.
- Parity:
  - P=16, `PAR_EN`=1, `PAR_TYP`=0, byte 0x3C with parity bit 0 → `Data_Valid`, `P_DATA`=0x3C.
  - Same byte with parity bit 1 → `Par_Err` at E0+177, `P_DATA` keeps 0x3C from the earlier frame.
- Stop error and glitch:
  - P=8, 0x5A sent with stop bit 0 → `Stop_Err` only, no `Data_Valid`.
  - `RX_IN` pulsed low for 2 cycles at P=16 → FSM returns to IDLE, no strobes.
  - A following 0x81 frame is received correctly.
- Back-to-back: P=32, odd parity, 0x00, 0xFF and 0x55 with no idle gap → three `Data_Valid` strobes exactly 11·32 cycles apart, with correct bytes.
- Reset mid-frame and config latching:
  - Assert `rst` during DATA bit 4 → no strobe.
  - Next full frame 0xC3 received correctly.
  - Toggle `PAR_EN` mid-frame → no effect on that frame.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote per bit,
// 8 data bits LSB first, optional even/odd parity, one-cycle outcome strobes.
module uart_rx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               Data_Valid,
  output logic               Par_Err,
  output logic               Stop_Err
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic [PRESC_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic [PRESC_W-1:0] r_presc;
  logic               r_par_en;
  logic               r_par_typ;
  logic               r_par_err;
  logic [2:0]         r_smp;

  logic [PRESC_W-1:0] w_half;
  logic               w_bit_end;
  logic               w_stop_end;
  logic               w_maj;

  always_comb begin
    w_half     = {1'b0, r_presc[PRESC_W-1:1]};
    w_bit_end  = (r_edge_cnt == r_presc - PRESC_W'(1));
    w_stop_end = (r_edge_cnt == r_presc - PRESC_W'(2));
    w_maj      = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_presc    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_err  <= 1'b0;
      r_smp      <= 3'b111;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;
    end else begin
      r_sync1    <= RX_IN;
      r_sync2    <= r_sync1;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stop_Err   <= 1'b0;

      if (r_state != StIdle) begin
        r_edge_cnt <= w_bit_end ? '0 : r_edge_cnt + PRESC_W'(1);
        if (r_edge_cnt == w_half - PRESC_W'(1)) r_smp[0] <= r_sync2;
        if (r_edge_cnt == w_half)               r_smp[1] <= r_sync2;
        if (r_edge_cnt == w_half + PRESC_W'(1)) r_smp[2] <= r_sync2;
      end

      unique case (r_state)
        StIdle: begin
          if (!r_sync2) begin
            r_state    <= StStart;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_par_err  <= 1'b0;
            r_presc    <= Prescale;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
          end
        end
        StStart: begin
          if (w_bit_end) r_state <= w_maj ? StIdle : StData;
        end
        StData: begin
          if (w_bit_end) begin
            r_shift   <= {w_maj, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(DATA_W - 1)) r_state <= r_par_en ? StParity : StStop;
          end
        end
        StParity: begin
          if (w_bit_end) begin
            r_par_err <= (w_maj != (^r_shift ^ r_par_typ));
            r_state   <= StStop;
          end
        end
        StStop: begin
          // Finish one cycle before the nominal bit end so a start bit that follows
          // immediately is picked up without slipping a cycle.
          if (w_stop_end) begin
            r_state    <= StIdle;
            r_edge_cnt <= '0;
            if (r_par_err) begin
              Par_Err <= 1'b1;
            end else if (!w_maj) begin
              Stop_Err <= 1'b1;
            end else begin
              Data_Valid <= 1'b1;
              P_DATA     <= r_shift;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: a frame-level driver pushes the expected
// outcome; a negedge monitor pops and checks kind, cycle and P_DATA.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stop_Err;

  uart_rx #(.DATA_W(8), .PRESC_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .Par_Err   (Par_Err),
    .Stop_Err  (Stop_Err)
  );

  always #5 clk = ~clk;

  // kind: 0 = Data_Valid, 1 = Par_Err, 2 = Stop_Err
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         nstrobes = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_pdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_pdata = 8'h00;
    end else if (Data_Valid || Par_Err || Stop_Err) begin
      nstrobes++;
      if (q.size() == 0) begin
        check("unexpected_strobe", {Data_Valid, Par_Err, Stop_Err}, 0);
      end else begin
        mon_e = q.pop_front();
        check("strobe_kind", {Data_Valid, Par_Err, Stop_Err}, 4 >> mon_e.kind);
        check("strobe_cycle", cyc, mon_e.cyc);
        check("strobe_pdata", P_DATA, mon_e.data);
        if (mon_e.kind == 0) exp_pdata = mon_e.data;
      end
    end else begin
      check("pdata_hold", P_DATA, exp_pdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a posedge; returns at the same phase, so frames can abut.
  task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                            input bit flip_par, input bit stop_bit, input bit track);
    int          n;
    exp_t        e;
    logic [10:0] bits;
    n        = pen ? 11 : 10;
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    bits     = '1;
    bits[0]  = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pen) bits[9] = ^d ^ ptyp ^ flip_par;
    bits[n-1] = stop_bit;
    if (track) begin
      // Line falls after edge cyc, so E0 = cyc+1 and the strobe lands at E0+1+N*P.
      e.cyc = cyc + 2 + n * p;
      if (pen && flip_par) e.kind = 1;
      else if (!stop_bit)  e.kind = 2;
      else                 e.kind = 0;
      e.data = (e.kind == 0) ? d : last_good;
      if (e.kind == 0) last_good = d;
      q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      RX_IN = bits[k];
      repeat (p) @(posedge clk);
      #1;
    end
    RX_IN = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pdata"}, P_DATA, 0);
    check({tag, "_strobes"}, {Data_Valid, Par_Err, Stop_Err}, 0);
  endtask

  initial begin
    int p_tab[3];
    int s0;
    int t;
    p_tab[0] = 8;
    p_tab[1] = 16;
    p_tab[2] = 32;

    idle(3);
    check_outputs_zero("reset_hold");
    rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_outputs_zero("async_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    s0 = nstrobes;
    idle(100);
    check("idle_no_strobe", nstrobes - s0, 0);

    send_frame(8, 0, 0, 8'hA5, 0, 1, 1);
    idle(5);
    send_frame(16, 1, 0, 8'h3C, 0, 1, 1);
    idle(5);
    send_frame(16, 1, 0, 8'h3C, 1, 1, 1);
    idle(5);
    send_frame(8, 0, 0, 8'h5A, 0, 0, 1);
    idle(10);

    // Two-cycle glitch must be rejected as a false start.
    Prescale = 6'd16;
    s0 = nstrobes;
    RX_IN = 1'b0;
    idle(2);
    RX_IN = 1'b1;
    idle(60);
    check("glitch_no_strobe", nstrobes - s0, 0);
    send_frame(16, 0, 0, 8'h81, 0, 1, 1);
    idle(5);

    send_frame(32, 1, 1, 8'h00, 0, 1, 1);
    send_frame(32, 1, 1, 8'hFF, 0, 1, 1);
    send_frame(32, 1, 1, 8'h55, 0, 1, 1);
    idle(5);

    // Reset during data bit 4 of an untracked frame; held until the line is idle.
    s0 = nstrobes;
    fork
      send_frame(8, 0, 0, 8'h96, 0, 1, 0);
      begin
        repeat (2 + 5 * 8 + 4) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_outputs_zero("midframe_reset");
      end
    join
    last_good = 8'h00;
    rst = 1'b0;
    idle(20);
    check("midframe_no_strobe", nstrobes - s0, 0);
    send_frame(8, 0, 0, 8'hC3, 0, 1, 1);
    idle(5);

    // Configuration changes mid-frame must not disturb the frame in flight.
    fork
      send_frame(16, 1, 0, 8'h6B, 0, 1, 1);
      begin
        idle(16 * 4);
        PAR_EN = 1'b0;
        PAR_TYP = 1'b1;
        Prescale = 6'd8;
      end
    join
    idle(3);
    fork
      send_frame(8, 0, 1, 8'h2E, 0, 1, 1);
      begin
        idle(8 * 3);
        PAR_EN = 1'b1;
        Prescale = 6'd32;
      end
    join
    idle(3);

    for (int i = 0; i < 24; i++) begin
      send_frame(p_tab[$urandom_range(0, 2)], 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0, 1);
      idle($urandom_range(0, 3));
    end

    t = 0;
    while (q.size() != 0 && t < 5000) begin
      idle(1);
      t++;
    end
    check("queue_drained", q.size(), 0);
    idle(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
